// File: rtl/gold_coin_controller.sv
// Gold coin life-cycle controller: respawn wait, visible lifetime, collect pulse,
// pseudo-random spawn slot and combinational rectangle/offset for the bitmap stage.
module gold_coin_controller #(
   parameter int OBJECT_WIDTH_X  = 32,
   parameter int OBJECT_HEIGHT_Y = 32,
   parameter int X_ORIGIN        = 64,
   parameter int X_STEP          = 64,
   parameter int Y_ORIGIN        = 48,
   parameter int Y_STEP          = 48,
   parameter int RESPAWN_FRAMES  = 4,
   parameter int LIFETIME_FRAMES = 250
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        startOfFrame,
   input  logic        collision,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        InsideRectangle,
   output logic        gold_ena,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        goldCollected
);

   typedef enum logic [1:0] {
      S_WAIT,
      S_VISIBLE,
      S_COLLECTED
   } state_t;

   localparam logic [7:0]  RESPAWN_LAST  = 8'(RESPAWN_FRAMES - 1);
   localparam logic [7:0]  LIFETIME_LAST = 8'(LIFETIME_FRAMES - 1);
   localparam logic [10:0] X_ORG         = 11'(X_ORIGIN);
   localparam logic [10:0] Y_ORG         = 11'(Y_ORIGIN);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nxt;
   logic [7:0]  r_lfsr;
   logic        r_coll;
   logic [10:0] r_top_x;
   logic [10:0] r_top_y;
   logic [10:0] w_top_x_nxt;
   logic [10:0] w_top_y_nxt;
   logic [10:0] w_spawn_x;
   logic [10:0] w_spawn_y;
   logic        w_hit;
   logic        w_lfsr_fb;
   logic [10:0] w_right_x;
   logic [10:0] w_bottom_y;
   logic        w_inside;

   // The latch remembers a mid-frame overlap; the live input covers an overlap
   // that coincides with the frame pulse itself.
   assign w_hit     = r_coll | collision;
   assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_spawn_x = X_ORG + 11'(r_lfsr[2:0]) * 11'(X_STEP);
   assign w_spawn_y = Y_ORG + 11'(r_lfsr[5:3]) * 11'(Y_STEP);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_lfsr <= 8'hA5;
         r_coll <= 1'b0;
      end else begin
         if (startOfFrame) begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            r_coll <= 1'b0;
         end else if (collision) begin
            r_coll <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= S_WAIT;
         r_cnt   <= '0;
         r_top_x <= X_ORG;
         r_top_y <= Y_ORG;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_top_x <= w_top_x_nxt;
         r_top_y <= w_top_y_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_top_x_nxt = r_top_x;
      w_top_y_nxt = r_top_y;
      case (r_state)
         S_WAIT: begin
            if (startOfFrame) begin
               if (r_cnt == RESPAWN_LAST) begin
                  w_state_nxt = S_VISIBLE;
                  w_cnt_nxt   = '0;
                  w_top_x_nxt = w_spawn_x;
                  w_top_y_nxt = w_spawn_y;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         S_VISIBLE: begin
            if (startOfFrame) begin
               if (w_hit) begin
                  w_state_nxt = S_COLLECTED;
               end else if (r_cnt == LIFETIME_LAST) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         S_COLLECTED: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign gold_ena      = (r_state != S_VISIBLE);
   assign goldCollected = (r_state == S_COLLECTED);
   assign topLeftX      = r_top_x;
   assign topLeftY      = r_top_y;

   assign w_right_x  = r_top_x + 11'(OBJECT_WIDTH_X);
   assign w_bottom_y = r_top_y + 11'(OBJECT_HEIGHT_Y);
   assign w_inside   = (pixelX >= r_top_x) && (pixelX < w_right_x) &&
                       (pixelY >= r_top_y) && (pixelY < w_bottom_y);

   assign InsideRectangle = w_inside;
   assign offsetX         = w_inside ? (pixelX - r_top_x) : '0;
   assign offsetY         = w_inside ? (pixelY - r_top_y) : '0;

endmodule

// File: tb/tb_gold_coin_controller.sv
// Scoreboard bench for gold_coin_controller: stimulus queues expected outputs,
// monitors compare on probe cycles and on every collect pulse.
module tb_gold_coin_controller;

   typedef struct packed {
      logic        ena;
      logic        col;
      logic [10:0] tx;
      logic [10:0] ty;
      logic        ins;
      logic [10:0] ox;
      logic [10:0] oy;
   } exp_t;

   logic        clk;
   logic        resetN;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        startOfFrame;
   logic        collision;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        InsideRectangle;
   logic        gold_ena;
   logic [10:0] topLeftX;
   logic [10:0] topLeftY;
   logic        goldCollected;

   exp_t  exp_q[$];
   string tag_q[$];
   string col_q[$];
   logic  probe;
   int    checks;
   int    errors;

   gold_coin_controller #(
      .LIFETIME_FRAMES(8)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .startOfFrame   (startOfFrame),
      .collision      (collision),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .InsideRectangle(InsideRectangle),
      .gold_ena       (gold_ena),
      .topLeftX       (topLeftX),
      .topLeftY       (topLeftY),
      .goldCollected  (goldCollected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Probe monitor: compares all outputs whenever stimulus raises probe.
   always @(negedge clk) begin
      if (probe) begin
         exp_t  e;
         exp_t  a;
         string t;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL probe_without_expectation");
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{ena: gold_ena, col: goldCollected, tx: topLeftX, ty: topLeftY,
                  ins: InsideRectangle, ox: offsetX, oy: offsetY};
            if (a !== e) begin
               errors = errors + 1;
               $display("FAIL %s got ena=%0b col=%0b top=(%0d,%0d) in=%0b off=(%0d,%0d) want ena=%0b col=%0b top=(%0d,%0d) in=%0b off=(%0d,%0d)",
                        t, a.ena, a.col, a.tx, a.ty, a.ins, a.ox, a.oy,
                        e.ena, e.col, e.tx, e.ty, e.ins, e.ox, e.oy);
            end
         end
      end
   end

   // Collect monitor: every cycle with goldCollected high must match a queued pulse.
   always @(negedge clk) begin
      if (goldCollected) begin
         checks = checks + 1;
         if (col_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_collect got goldCollected=1 want 0 at %0t", $time);
         end else begin
            void'(col_q.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      tick(2);
   endtask

   task automatic probe_at(input string tag, input int px, input int py,
                           input logic ena, input logic col, input int tx, input int ty,
                           input logic ins, input int ox, input int oy);
      exp_t e;
      e = '{ena: ena, col: col, tx: 11'(tx), ty: 11'(ty), ins: ins, ox: 11'(ox), oy: 11'(oy)};
      pixelX = 11'(px);
      pixelY = 11'(py);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      probe = 1'b1;
      @(negedge clk);
      #1 probe = 1'b0;
   endtask

   task automatic expect_state(input string tag, input logic ena, input logic col,
                               input int tx, input int ty);
      probe_at(tag, 0, 0, ena, col, tx, ty, 1'b0, 0, 0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      probe        = 1'b0;
      resetN       = 1'b0;
      pixelX       = '0;
      pixelY       = '0;
      startOfFrame = 1'b0;
      collision    = 1'b0;
      tick(2);
      expect_state("reset_state", 1'b1, 1'b0, 64, 48);
      resetN = 1'b1;
      tick(1);

      // Spawn: lfsr A5->4A->95->2A, slot taken from 2A
      for (int i = 0; i < 3; i++) begin
         frame();
         expect_state($sformatf("wait_frame%0d", i + 1), 1'b1, 1'b0, 64, 48);
      end
      frame();
      expect_state("spawn_pos", 1'b0, 1'b0, 192, 288);
      probe_at("pix_inside",      200, 300, 1'b0, 1'b0, 192, 288, 1'b1, 8, 12);
      probe_at("pix_right_edge",  224, 300, 1'b0, 1'b0, 192, 288, 1'b0, 0, 0);
      probe_at("pix_top_left",    192, 288, 1'b0, 1'b0, 192, 288, 1'b1, 0, 0);
      probe_at("pix_bottom_right",223, 319, 1'b0, 1'b0, 192, 288, 1'b1, 31, 31);
      probe_at("pix_left_out",    191, 300, 1'b0, 1'b0, 192, 288, 1'b0, 0, 0);
      probe_at("pix_bottom_out",  200, 320, 1'b0, 1'b0, 192, 288, 1'b0, 0, 0);

      // Collect via mid-frame collision latch
      collision = 1'b1;
      tick(1);
      collision = 1'b0;
      expect_state("collide_no_change", 1'b0, 1'b0, 192, 288);
      startOfFrame = 1'b1;
      col_q.push_back("collect_latch");
      tick(1);
      startOfFrame = 1'b0;
      expect_state("collected_cycle", 1'b1, 1'b1, 192, 288);
      tick(1);
      expect_state("collected_one_cycle", 1'b1, 1'b0, 192, 288);

      // Respawn: lfsr 54->A9->53->A7->4E, slot from 4E; collision in WAIT ignored
      for (int i = 0; i < 3; i++) begin
         frame();
         expect_state($sformatf("respawn_wait%0d", i + 1), 1'b1, 1'b0, 192, 288);
      end
      collision = 1'b1;
      tick(1);
      collision = 1'b0;
      tick(1);
      frame();
      expect_state("respawn_pos", 1'b0, 1'b0, 448, 96);
      frame();
      expect_state("wait_latch_dropped", 1'b0, 1'b0, 448, 96);

      // Timeout after 8 visible frames, no pulse
      for (int i = 2; i < 8; i++) begin
         frame();
         expect_state($sformatf("visible_frame%0d", i), 1'b0, 1'b0, 448, 96);
      end
      frame();
      expect_state("timeout_hide", 1'b1, 1'b0, 448, 96);

      // Respawn from CF, then collision on the timeout frame
      for (int i = 0; i < 4; i++) frame();
      expect_state("respawn2_pos", 1'b0, 1'b0, 512, 96);
      for (int i = 0; i < 7; i++) frame();
      expect_state("before_tie", 1'b0, 1'b0, 512, 96);
      startOfFrame = 1'b1;
      collision    = 1'b1;
      col_q.push_back("collect_tie");
      tick(1);
      startOfFrame = 1'b0;
      collision    = 1'b0;
      expect_state("tie_collected", 1'b1, 1'b1, 512, 96);
      tick(1);
      expect_state("tie_after", 1'b1, 1'b0, 512, 96);

      // Reach VISIBLE, run to frame 3, then reset mid-frame
      for (int i = 0; i < 4; i++) frame();
      for (int i = 0; i < 3; i++) frame();
      resetN = 1'b0;
      expect_state("reset_mid_visible", 1'b1, 1'b0, 64, 48);
      tick(1);
      resetN = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) frame();
      expect_state("rerun_wait3", 1'b1, 1'b0, 64, 48);
      frame();
      probe_at("rerun_spawn", 200, 300, 1'b0, 1'b0, 192, 288, 1'b1, 8, 12);

      // Reset during COLLECTED drops the pulse at once
      startOfFrame = 1'b1;
      collision    = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      collision    = 1'b0;
      resetN       = 1'b0;
      expect_state("reset_in_collected", 1'b1, 1'b0, 64, 48);
      tick(1);
      resetN = 1'b1;
      tick(2);

      checks = checks + 1;
      if (col_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL missing_collect got %0d pulses outstanding want 0", col_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gold_coin_controller.md
# gold_coin_controller

Upstream driver for the gold coin bitmap stage in the VGA object chain. It owns the coin's life cycle: hidden respawn wait, visible with lifetime, collected. It picks a pseudo-random spawn slot on each appearance and converts the scan pixel into the rectangle-hit and offset signals that the bitmap stage consumes. It also emits a one-cycle `goldCollected` pulse to the score logic.

## Interface
Parameters:
- `OBJECT_WIDTH_X`, default 32: on-screen coin width in pixels (16-pixel bitmap scaled ×2).
- `OBJECT_HEIGHT_Y`, default 32: on-screen coin height.
- `X_ORIGIN`, default 64: X of spawn slot 0.
- `X_STEP`, default 64: X spacing between slots.
- `Y_ORIGIN`, default 48: Y of spawn slot 0.
- `Y_STEP`, default 48: Y spacing between slots.
- `RESPAWN_FRAMES`, default 4: frames hidden before appearing, 1..255.
- `LIFETIME_FRAMES`, default 250: frames visible before timeout, 1..255.

Ports:
- `clk`, in, 1: pixel clock.
- `resetN`, in, 1: asynchronous active-low reset.
- `pixelX`, in, 11: current scan X.
- `pixelY`, in, 11: current scan Y.
- `startOfFrame`, in, 1: one-cycle pulse, once per frame.
- `collision`, in, 1: tank/coin overlap, any cycle.
- `offsetX`, out, 11: pixelX − topLeftX when inside, else 0.
- `offsetY`, out, 11: pixelY − topLeftY when inside, else 0.
- `InsideRectangle`, out, 1: pixel is within the coin rectangle.
- `gold_ena`, out, 1: 1 = coin hidden. The bitmap stage suppresses drawing while this is 1.
- `topLeftX`, out, 11: registered coin X.
- `topLeftY`, out, 11: registered coin Y.
- `goldCollected`, out, 1: one-cycle collect pulse.

## Operation
- **Reset state:**
  - FSM in `WAIT`, frame counter `cnt` = 0, `lfsr` = 8'hA5, collision latch = 0.
  - `topLeftX` = X_ORIGIN, `topLeftY` = Y_ORIGIN.
  - `gold_ena` = 1, `goldCollected` = 0.
- **LFSR:** 8-bit, polynomial x^8+x^6+x^5+x^4+1.
  - Advances only on `startOfFrame` cycles: `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - Never reaches 0.
- **Collision latch:** set by `collision` in any cycle. Cleared on every `startOfFrame` cycle.
- **Effective collision:** `hit` = latch | `collision`, evaluated on the `startOfFrame` cycle.
- **FSM:** states `WAIT`, `VISIBLE`, `COLLECTED`. Transitions are evaluated only on `startOfFrame` cycles, except `COLLECTED`.
  - **WAIT:**
    - If `cnt` == RESPAWN_FRAMES−1: go to `VISIBLE`, clear `cnt`, and latch position from the pre-advance `lfsr`: `topLeftX` = X_ORIGIN + lfsr[2:0]·X_STEP, `topLeftY` = Y_ORIGIN + lfsr[5:3]·Y_STEP.
    - Otherwise increment `cnt`.
    - `hit` is ignored in this state.
  - **VISIBLE:**
    - If `hit`: go to `COLLECTED`. Collision takes priority over timeout.
    - Else if `cnt` == LIFETIME_FRAMES−1: go to `WAIT`, clear `cnt`. No pulse.
    - Otherwise increment `cnt`.
  - **COLLECTED:** lasts exactly one cycle, then goes to `WAIT` with `cnt` cleared.
- **Moore outputs:** `gold_ena` = (state != `VISIBLE`); `goldCollected` = (state == `COLLECTED`).
- **Rectangle hit:** `InsideRectangle` = (pixelX ≥ topLeftX) & (pixelX < topLeftX+OBJECT_WIDTH_X) & (pixelY ≥ topLeftY) & (pixelY < topLeftY+OBJECT_HEIGHT_Y).
  - All comparisons are 11-bit unsigned.
  - Parameters must guarantee that no sum exceeds 2047.
- **Rectangle independence:** the rectangle and offsets are computed regardless of `gold_ena`. Hiding is done by the bitmap stage.

## Timing
- Rectangle path is combinational from `pixelX`/`pixelY` and the registered top-left: zero latency. The bitmap stage adds its own 1 cycle.
- State, `cnt`, `lfsr`, `topLeft*` update on the `clk` edge that ends the `startOfFrame` cycle. `gold_ena` changes from the following cycle.
- `topLeft*` change only when entering `VISIBLE`. Position is therefore stable for the whole visible lifetime.
- `goldCollected` is high for exactly the one cycle after the deciding `startOfFrame` cycle.
- Reset is asynchronous at any point, including mid-`VISIBLE` or during `COLLECTED`. It immediately forces all reset values, and `goldCollected` drops at once.

## Test plan
1. **Reset:** assert `resetN`=0 mid-frame → `gold_ena`=1, `goldCollected`=0, `topLeft` = (64,48), FSM in `WAIT`.
2. **Spawn:** defaults, 4 `startOfFrame` pulses after reset → `lfsr` sequence A5→4A→95→2A, so the 4th pulse spawns at (192,288) and `gold_ena`=0 the next cycle.
   - Pixel (200,300) → `InsideRectangle`=1, offset (8,12).
   - Pixel (224,300) → `InsideRectangle`=0, offset (0,0).
3. **Collect:** while `VISIBLE`, pulse `collision` for one cycle mid-frame → no change until the next `startOfFrame`. In the following cycle `goldCollected`=1 for exactly one cycle and `gold_ena`=1. The coin reappears after 4 more `startOfFrame` pulses.
4. **Timeout:** `LIFETIME_FRAMES`=8, no collision → `gold_ena` returns to 1 after the 8th visible `startOfFrame`, `goldCollected` never asserts.
5. **Simultaneous and ignored events:**
   - `collision` high on the same `startOfFrame` that would time out → `COLLECTED` wins, pulse seen.
   - `collision` while in `WAIT` → no pulse, and the latch does not carry into `VISIBLE`.
6. **Mid-operation reset:** reset asserted during `VISIBLE` at frame 3 → immediate hide, `topLeft` = (64,48). After release the spawn sequence repeats exactly as in scenario 2.
